// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - mode codes and default timing constants for the LED sequencer
package led_pkg;
   typedef logic [1:0] mode_t;

   localparam mode_t MODE_IDLE    = 2'b00;
   localparam mode_t MODE_CHASE_L = 2'b01;
   localparam mode_t MODE_CHASE_R = 2'b10;
   localparam mode_t MODE_BLINK   = 2'b11;

   localparam logic [20:0] LED_T_TICK     = 21'd2_000_000;
   localparam logic [20:0] LED_DUTY_ON    = 21'd500_000;
   localparam logic [7:0]  LED_STEP_TICKS = 8'd25;
   localparam int          LED_N          = 4;
endpackage

// File: rtl/led_sequencer_if.sv
// rtl/led_sequencer_if.sv - mode command valid/ready handshake
interface led_sequencer_if;
   import led_pkg::*;

   mode_t Mode_In;
   logic  Mode_Valid;
   logic  Mode_Ready;

   modport master (output Mode_In, output Mode_Valid, input Mode_Ready);
   modport slave  (input Mode_In, input Mode_Valid, output Mode_Ready);
endinterface

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - shared period counter, tick strobe and duty-window compare
module led_tick_gen import led_pkg::*; #(
   parameter logic [20:0] T_TICK  = LED_T_TICK,
   parameter logic [20:0] DUTY_ON = LED_DUTY_ON
) (
   input  logic CLK,
   input  logic RSTn,
   input  logic Run_En,
   input  logic Clr,
   output logic Tick,
   output logic On_Win
);
   logic [20:0] cnt_q, cnt_d;

   // Clr wins over Run_En so an idle-state mode entry restarts timing even while frozen
   always_comb begin
      cnt_d = cnt_q;
      if (Clr)
         cnt_d = 21'd0;
      else if (Run_En)
         cnt_d = (cnt_q == T_TICK) ? 21'd0 : cnt_q + 21'd1;
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn)
         cnt_q <= 21'd0;
      else
         cnt_q <= cnt_d;
   end

   assign Tick   = (cnt_q == T_TICK) && Run_En;
   assign On_Win = (cnt_q < DUTY_ON);
endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - LED pattern sequencer: command slot, mode FSM, step counter, gated output
module led_sequencer import led_pkg::*; #(
   parameter logic [20:0] T_TICK     = LED_T_TICK,
   parameter logic [20:0] DUTY_ON    = LED_DUTY_ON,
   parameter logic [7:0]  STEP_TICKS = LED_STEP_TICKS,
   parameter int          N_LED      = LED_N
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             Run_En,
   led_sequencer_if.slave   mode_if,
   output logic             Step_Pulse,
   output mode_t            State_Out,
   output logic [N_LED-1:0] LED_Out
);
   logic             tick, on_win, clr, boundary, accept, apply;
   logic             pend_valid_q, pend_valid_d;
   mode_t            pend_mode_q, pend_mode_d;
   mode_t            state_q, state_d;
   logic [7:0]       step_q, step_d;
   logic [N_LED-1:0] pattern_q, pattern_d;
   logic [N_LED-1:0] led_q, led_d;
   logic             pulse_q, pulse_d;

   led_tick_gen #(.T_TICK(T_TICK), .DUTY_ON(DUTY_ON)) u_tick_gen (
      .CLK    (CLK),
      .RSTn   (RSTn),
      .Run_En (Run_En),
      .Clr    (clr),
      .Tick   (tick),
      .On_Win (on_win)
   );

   function automatic logic [N_LED-1:0] entry_pattern(input mode_t m);
      case (m)
         MODE_CHASE_L: entry_pattern = {{(N_LED-1){1'b0}}, 1'b1};
         MODE_CHASE_R: entry_pattern = {1'b1, {(N_LED-1){1'b0}}};
         MODE_BLINK:   entry_pattern = {N_LED{1'b1}};
         default:      entry_pattern = '0;
      endcase
   endfunction

   always_comb begin
      boundary     = tick && (step_q == STEP_TICKS - 8'd1);
      accept       = mode_if.Mode_Valid && !pend_valid_q;
      // idle does not wait for a step boundary: pending applies at once and restarts timing
      clr          = (state_q == MODE_IDLE) && pend_valid_q;
      apply        = clr || (boundary && pend_valid_q);

      state_d      = state_q;
      pattern_d    = pattern_q;
      step_d       = step_q;
      pend_valid_d = pend_valid_q;
      pend_mode_d  = pend_mode_q;

      if (tick)
         step_d = boundary ? 8'd0 : step_q + 8'd1;
      if (clr)
         step_d = 8'd0;

      if (apply) begin
         state_d      = pend_mode_q;
         pattern_d    = entry_pattern(pend_mode_q);
         pend_valid_d = 1'b0;
      end else if (boundary) begin
         case (state_q)
            MODE_CHASE_L: pattern_d = {pattern_q[N_LED-2:0], pattern_q[N_LED-1]};
            MODE_CHASE_R: pattern_d = {pattern_q[0], pattern_q[N_LED-1:1]};
            MODE_BLINK:   pattern_d = ~pattern_q;
            default:      pattern_d = '0;
         endcase
      end

      if (accept) begin
         pend_valid_d = 1'b1;
         pend_mode_d  = mode_if.Mode_In;
      end

      pulse_d = boundary && (state_q != MODE_IDLE);
      led_d   = Run_En ? (pattern_q & {N_LED{on_win}}) : led_q;
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q      <= MODE_IDLE;
         pattern_q    <= '0;
         step_q       <= 8'd0;
         pend_valid_q <= 1'b0;
         pend_mode_q  <= MODE_IDLE;
         led_q        <= '0;
         pulse_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pattern_q    <= pattern_d;
         step_q       <= step_d;
         pend_valid_q <= pend_valid_d;
         pend_mode_q  <= pend_mode_d;
         led_q        <= led_d;
         pulse_q      <= pulse_d;
      end
   end

   assign mode_if.Mode_Ready = !pend_valid_q;
   assign Step_Pulse         = pulse_q;
   assign State_Out          = state_q;
   assign LED_Out            = led_q;
endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - randomized and directed self-checking bench for led_sequencer
module tb_led_sequencer;
   localparam int T = 9;
   localparam int D = 5;
   localparam int S = 2;

   logic       CLK = 1'b0;
   logic       RSTn = 1'b0;
   logic       Run_En = 1'b1;
   logic       Step_Pulse;
   logic [1:0] State_Out;
   logic [3:0] LED_Out;

   int n_cmp = 0;
   int n_bad = 0;
   bit checking = 0;

   led_sequencer_if bus ();

   led_sequencer #(.T_TICK(21'd9), .DUTY_ON(21'd5), .STEP_TICKS(8'd2), .N_LED(4)) dut (
      .CLK        (CLK),
      .RSTn       (RSTn),
      .Run_En     (Run_En),
      .mode_if    (bus),
      .Step_Pulse (Step_Pulse),
      .State_Out  (State_Out),
      .LED_Out    (LED_Out)
   );

   always #5 CLK = ~CLK;

   // reference model: counters as plain integers, pending command as a queue
   int m_cnt = 0, m_step = 0, m_mode = 0, m_pat = 0, m_led = 0;
   bit m_pulse = 0;
   int m_pend[$];

   function automatic int entry(input int m);
      case (m)
         1: return 1;
         2: return 8;
         3: return 15;
         default: return 0;
      endcase
   endfunction

   function automatic int advance(input int m, input int p);
      case (m)
         1: return ((p * 2) % 16) + (p / 8);
         2: return (p / 2) + ((p % 2) * 8);
         3: return 15 - p;
         default: return 0;
      endcase
   endfunction

   always @(posedge CLK or negedge RSTn) begin
      int o_cnt, o_step, o_mode, o_pat;
      bit tk, bnd, acc;
      if (!RSTn) begin
         m_cnt = 0; m_step = 0; m_mode = 0; m_pat = 0; m_led = 0; m_pulse = 0;
         m_pend.delete();
      end else begin
         o_cnt = m_cnt; o_step = m_step; o_mode = m_mode; o_pat = m_pat;
         tk  = Run_En && (o_cnt == T);
         bnd = tk && (o_step == S - 1);
         acc = bus.Mode_Valid && (m_pend.size() == 0);
         m_pulse = bnd && (o_mode != 0);
         if (Run_En) begin
            m_led = (o_cnt < D) ? o_pat : 0;
            m_cnt = (o_cnt + 1) % (T + 1);
         end
         if (tk) m_step = (o_step + 1) % S;
         if (o_mode == 0 && m_pend.size() > 0) begin
            m_mode = m_pend.pop_front();
            m_pat = entry(m_mode);
            m_cnt = 0;
            m_step = 0;
         end else if (bnd) begin
            if (m_pend.size() > 0) begin
               m_mode = m_pend.pop_front();
               m_pat = entry(m_mode);
            end else begin
               m_pat = advance(o_mode, o_pat);
            end
         end
         if (acc) m_pend.push_back(int'(bus.Mode_In));
      end
   end

   always @(negedge CLK) begin
      if (checking) begin
         n_cmp++;
         if (int'(LED_Out) != m_led || int'(State_Out) != m_mode || Step_Pulse != m_pulse ||
             bus.Mode_Ready != (m_pend.size() == 0)) begin
            n_bad++;
            $display("FAIL outputs t=%0t: led=%b state=%0d pulse=%0b ready=%0b required led=%0d state=%0d pulse=%0b ready=%0b",
                     $time, LED_Out, State_Out, Step_Pulse, bus.Mode_Ready,
                     m_led, m_mode, m_pulse, (m_pend.size() == 0));
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge CLK);
      #2;
   endtask

   task automatic send(input logic [1:0] m);
      bit ok;
      ok = 0;
      bus.Mode_In = m;
      bus.Mode_Valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge CLK);
         if (bus.Mode_Ready) begin
            @(posedge CLK);
            #1;
            ok = 1;
            break;
         end
      end
      bus.Mode_Valid = 1'b0;
      chk("send_accepted", int'(ok), 1);
   endtask

   task automatic wait_pulse(input string name);
      bit seen;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (Step_Pulse) begin
            seen = 1;
            break;
         end
      end
      chk(name, int'(seen), 1);
   endtask

   initial begin
      bit seen;
      int on_cnt;
      logic [3:0] frozen;
      bus.Mode_In = 2'b00;
      bus.Mode_Valid = 1'b0;
      repeat (2) @(posedge CLK);
      checking = 1;
      #1 RSTn = 1'b1;
      #1;
      chk("rst_led", int'(LED_Out), 0);
      chk("rst_state", int'(State_Out), 0);
      chk("rst_ready", int'(bus.Mode_Ready), 1);

      // idle: no step pulses
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (Step_Pulse) seen = 1;
      end
      chk("idle_no_pulse", int'(seen), 0);
      chk("idle_led", int'(LED_Out), 0);

      // chase-left entry from idle and walking pattern
      @(posedge CLK); #1;
      send(2'b01);
      edges(1);
      chk("cl_state", int'(State_Out), 1);
      edges(1);
      for (int j = 0; j < 4; j++) begin
         chk("cl_led_on", int'(LED_Out), 1 << j);
         edges(5);
         chk("cl_led_off", int'(LED_Out), 0);
         edges(14);
         chk("cl_pulse", int'(Step_Pulse), 1);
         edges(1);
      end
      chk("cl_wrap", int'(LED_Out), 1);
      on_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         if (LED_Out != 4'b0000) on_cnt++;
      end
      chk("duty_on_count", on_cnt, 5);

      // chase-right mid-step, then blink held behind it
      edges(3);
      bus.Mode_In = 2'b10;
      bus.Mode_Valid = 1'b1;
      @(posedge CLK); #1;
      bus.Mode_In = 2'b11;
      #1;
      chk("hold_ready_low", int'(bus.Mode_Ready), 0);
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (bus.Mode_Ready) begin
            seen = 1;
            break;
         end
      end
      chk("ready_returns", int'(seen), 1);
      chk("cr_state", int'(State_Out), 2);
      @(posedge CLK); #1;
      bus.Mode_Valid = 1'b0;
      #1;
      chk("cr_entry_led", int'(LED_Out), 8);
      chk("blink_pending", int'(bus.Mode_Ready), 0);
      wait_pulse("blink_boundary");
      chk("blink_state", int'(State_Out), 3);
      edges(1);
      chk("blink_on", int'(LED_Out), 15);
      edges(20);
      chk("blink_inv", int'(LED_Out), 0);

      // chase-right with a run freeze mid-step
      send(2'b10);
      wait_pulse("cr2_boundary");
      chk("cr2_state", int'(State_Out), 2);
      edges(5);
      Run_En = 1'b0;
      frozen = LED_Out;
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         if (Step_Pulse || LED_Out != frozen) seen = 1;
      end
      chk("freeze_hold", int'(seen), 0);
      @(posedge CLK); #1;
      Run_En = 1'b1;
      edges(40);

      // reset with blink active and a command pending
      send(2'b11);
      wait_pulse("blink2_boundary");
      edges(4);
      send(2'b01);
      edges(3);
      RSTn = 1'b0;
      #1;
      chk("mid_rst_led", int'(LED_Out), 0);
      chk("mid_rst_state", int'(State_Out), 0);
      chk("mid_rst_ready", int'(bus.Mode_Ready), 1);
      chk("mid_rst_pulse", int'(Step_Pulse), 0);
      edges(2);
      RSTn = 1'b1;
      edges(30);
      chk("post_rst_state", int'(State_Out), 0);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         @(posedge CLK); #1;
         Run_En = ($urandom % 10) != 0;
         bus.Mode_Valid = ($urandom % 8) == 0;
         bus.Mode_In = 2'($urandom % 4);
         RSTn = ($urandom % 1500) != 0;
      end
      @(posedge CLK); #1;
      RSTn = 1'b1;
      bus.Mode_Valid = 1'b0;
      edges(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
